// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding and default bus width.
package fetch_pkg;

  localparam int BUS_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {pc, instr} pairs with single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W = BUS_WIDTH_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_instr,
  output logic [DATA_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  // Storage is data only and never reset; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: BOOT/RUN/HALT FSM, PC sequencing, redirect and fetch queue.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [BUS_WIDTH-1:0] F_PC,
  input  logic [BUS_WIDTH-1:0] Instr,
  input  logic                 redir_valid,
  input  logic [BUS_WIDTH-1:0] redir_pc,
  input  logic                 halt_req,
  output logic                 D_valid,
  input  logic                 D_ready,
  output logic [BUS_WIDTH-1:0] D_Instr,
  output logic [BUS_WIDTH-1:0] D_PC,
  output logic                 halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          fetch_count,
  output logic [31:0]          stall_count
`endif
);

  localparam int              CNT_W    = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic             run_st;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             pop;
  logic             push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Redirect wins over halt, and also wakes the FSM out of HALT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (!redir_valid && halt_req) state_nxt = ST_HALT;
      ST_HALT: if (redir_valid) state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    run_st = (state == ST_RUN);
    halted = (state == ST_HALT);
  end

  assign q_full  = (q_count == FULL_CNT);
  assign D_valid = (q_count != '0) & ~redir_valid;
  assign pop     = D_valid & D_ready;
  assign push    = run_st & ~redir_valid & ~halt_req & (~q_full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           F_PC <= '0;
    else if (redir_valid) F_PC <= redir_pc;
    else if (push)        F_PC <= F_PC + BUS_WIDTH'(1);
  end

  fetch_queue #(
    .DATA_W (BUS_WIDTH),
    .DEPTH  (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redir_valid),
    .push       (push),
    .pop        (pop),
    .push_pc    (F_PC),
    .push_instr (Instr),
    .head_pc    (D_PC),
    .head_instr (D_Instr),
    .count      (q_count)
  );

`ifdef FETCH_PERF_EN
  logic stall;

  // A stall is a RUN cycle that wanted to fetch but found the queue full with no pop.
  assign stall = run_st & ~redir_valid & ~halt_req & q_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)  fetch_count <= fetch_count + 32'd1;
      if (stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default QDEPTH=4, BUS_WIDTH=32).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] F_PC;
  logic [31:0] Instr;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        halt_req;
  logic        D_valid;
  logic        D_ready;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .F_PC        (F_PC),
    .Instr       (Instr),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt_req    (halt_req),
    .D_valid     (D_valid),
    .D_ready     (D_ready),
    .D_Instr     (D_Instr),
    .D_PC        (D_PC),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb Instr = mem(F_PC);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge of cycle 1 (first RUN cycle, F_PC=0).
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0; redir_valid = 1'b0; halt_req = 1'b0; D_ready = rdy;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redir_valid = 1'b0; redir_pc = '0; halt_req = 1'b0; D_ready = 1'b1;
    #2;
    chk("rst_fpc",     F_PC,    32'd0);
    chk("rst_dvalid",  D_valid, 32'd0);
    chk("rst_halted",  halted,  32'd0);

    // Basic flow
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("c1_fpc",    F_PC,    32'd0);
    chk("c1_dvalid", D_valid, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("flow_fpc",    F_PC,    32'(i));
      chk("flow_dvalid", D_valid, 32'd1);
      chk("flow_dpc",    D_PC,    32'(i - 1));
      chk("flow_dinstr", D_Instr, mem(32'(i - 1)));
    end

    // Backpressure
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    chk("bp_fpc",    F_PC,    32'd4);
    chk("bp_dvalid", D_valid, 32'd1);
    chk("bp_dpc",    D_PC,    32'd0);
    chk("bp_dinstr", D_Instr, mem(32'd0));
`ifdef FETCH_PERF_EN
    chk("bp_fetch_count", fetch_count, 32'd4);
    chk("bp_stall_count", stall_count, 32'd6);
`endif
    // Full queue with a pop: push and pop together
    D_ready = 1'b1;
    @(negedge clk); D_ready = 1'b0;
    chk("fullpop_fpc",    F_PC,    32'd5);
    chk("fullpop_dpc",    D_PC,    32'd1);
    chk("fullpop_dinstr", D_Instr, mem(32'd1));
    @(negedge clk);
    chk("fullhold_fpc", F_PC, 32'd5);
    chk("fullhold_dpc", D_PC, 32'd1);

    // Redirect with full queue
    redir_valid = 1'b1; redir_pc = 32'd6;
    #1 chk("redir_dvalid_comb", D_valid, 32'd0);
    @(negedge clk); redir_valid = 1'b0;
    chk("redir_dvalid", D_valid, 32'd0);
    chk("redir_fpc",    F_PC,    32'd6);
    D_ready = 1'b1;
    @(negedge clk);
    chk("redir_fpc7",   F_PC,    32'd7);
    chk("redir_dpc6",   D_PC,    32'd6);
    chk("redir_dinstr", D_Instr, mem(32'd6));
    @(negedge clk);
    chk("redir_dpc7",   D_PC,    32'd7);

    // Halt and drain
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    chk("halt_pre_fpc", F_PC, 32'd3);
    halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    chk("halt_halted", halted, 32'd1);
    chk("halt_fpc",    F_PC,   32'd3);
    chk("halt_dpc0",   D_PC,   32'd0);
    D_ready = 1'b1;
    @(negedge clk);
    chk("drain_dpc1", D_PC, 32'd1);
    chk("drain_fpc",  F_PC, 32'd3);
    @(negedge clk);
    chk("drain_dpc2", D_PC, 32'd2);
    @(negedge clk);
    chk("drain_empty",  D_valid, 32'd0);
    chk("drain_fpc3",   F_PC,    32'd3);
    chk("drain_halted", halted,  32'd1);
    redir_valid = 1'b1; redir_pc = 32'd1;
    @(negedge clk); redir_valid = 1'b0;
    chk("resume_halted", halted,  32'd0);
    chk("resume_fpc",    F_PC,    32'd1);
    chk("resume_dvalid", D_valid, 32'd0);
    @(negedge clk);
    chk("resume_fpc2",   F_PC,    32'd2);
    chk("resume_dpc",    D_PC,    32'd1);
    chk("resume_dinstr", D_Instr, mem(32'd1));

    // Wrap and redirect/halt collision
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFF; halt_req = 1'b1;
    @(negedge clk); redir_valid = 1'b0; halt_req = 1'b0;
    chk("coll_halted", halted,  32'd0);
    chk("coll_fpc",    F_PC,    32'hFFFF_FFFF);
    chk("coll_dvalid", D_valid, 32'd0);
    @(negedge clk);
    chk("wrap_fpc",    F_PC,    32'd0);
    chk("wrap_dpc",    D_PC,    32'hFFFF_FFFF);
    chk("wrap_dinstr", D_Instr, mem(32'hFFFF_FFFF));
    chk("wrap_halted", halted,  32'd0);

    // Asynchronous reset mid-run with three entries queued
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    chk("mid_pre_dvalid", D_valid, 32'd1);
    chk("mid_pre_fpc",    F_PC,    32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dvalid", D_valid, 32'd0);
    chk("mid_rst_fpc",    F_PC,    32'd0);
    chk("mid_rst_halted", halted,  32'd0);
`ifdef FETCH_PERF_EN
    chk("mid_rst_fetch_count", fetch_count, 32'd0);
    chk("mid_rst_stall_count", stall_count, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_dvalid", D_valid, 32'd0);
    chk("post_rst_fpc",    F_PC,    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, width of the PC and instruction buses.
REQ-002 SHALL have parameter QDEPTH, default 4, the fetch-queue depth; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port F_PC, output, BUS_WIDTH, the word address driven to instructionMemory.
REQ-006 SHALL have port Instr, input, BUS_WIDTH, the combinational instruction-memory read data for F_PC.
REQ-007 SHALL have port redir_valid, input, 1, the branch/jump redirect strobe.
REQ-008 SHALL have port redir_pc, input, BUS_WIDTH, the redirect target.
REQ-009 SHALL have port halt_req, input, 1, the request to stop fetching.
REQ-010 SHALL have port D_valid, output, 1, meaning the queue head is presented to decode.
REQ-011 SHALL have port D_ready, input, 1, meaning decode accepts the head.
REQ-012 SHALL have port D_Instr, output, BUS_WIDTH, the head instruction.
REQ-013 SHALL have port D_PC, output, BUS_WIDTH, the head instruction's address.
REQ-014 SHALL have port halted, output, 1, high while the FSM is in HALT.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and HALT: BOOT->RUN unconditionally after one cycle; RUN->HALT on halt_req; HALT->RUN on redir_valid; no other transitions.
REQ-016 SHALL fetch (push {F_PC, Instr}, F_PC<=F_PC+1) in a cycle only when the state is RUN, redir_valid=0, halt_req=0, and either count<QDEPTH or a pop occurs in the same cycle.
REQ-017 SHALL increment F_PC modulo 2^BUS_WIDTH, so 0xFFFFFFFF wraps to 0.
REQ-018 SHALL drive D_valid = (count!=0) & ~redir_valid; a pop SHALL occur iff D_valid & D_ready.
REQ-019 SHALL present the instruction fetched in cycle N on D_Instr no earlier than cycle N+1 (one-cycle latency, first-word-fall-through queue).
REQ-020 SHALL, on redir_valid, empty the queue, load F_PC<=redir_pc, and perform neither a push nor a pop in that cycle; the state becomes RUN.
REQ-021 SHALL give redir_valid priority over halt_req when both are asserted in the same cycle.
REQ-022 SHALL hold D_Instr/D_PC stable while D_valid=1 and D_ready=0.
REQ-023 SHALL, when full with a simultaneous pop, push and pop in the same cycle, leaving count unchanged.
REQ-024 SHALL, in HALT, keep F_PC frozen and let decode drain the queue.

Reset
REQ-025 SHALL on rst_n=0 immediately set F_PC=0, count=0, read/write pointers=0, state=BOOT, D_valid=0 and halted=0.
REQ-026 SHALL discard all queue contents on reset asserted mid-operation; D_Instr/D_PC are don't-care while D_valid=0.

Configuration
REQ-027 SHALL, with FETCH_PERF_EN defined, add outputs fetch_count[31:0] (pushes) and stall_count[31:0] (RUN cycles blocked by a full queue), both reset to 0 and wrapping.
REQ-028 SHALL, without FETCH_PERF_EN, omit these ports and counters entirely, with behaviour otherwise identical.

Structure
REQ-029 SHALL take the FSM state encoding and the BUS_WIDTH default from shared package fetch_pkg.
REQ-030 SHALL implement the queue as sub-module fetch_queue (FWFT FIFO with flush, push, pop, count).

Verification
REQ-031 SHALL cover basic flow: reset, D_ready=1 -> F_PC sequence 0,1,2,3 from cycle 1, with D_PC=0 in cycle 2 carrying mem[0].
REQ-032 SHALL cover backpressure: D_ready=0 for 10 cycles -> exactly 4 pushes, F_PC holds at 4, D_PC holds at 0.
REQ-033 SHALL cover redirect: redir_pc=6 with queue full -> next cycle count=0, D_valid=0, F_PC=6; then D_PC=6, D_PC=7 in order.
REQ-034 SHALL cover halt: halt_req at F_PC=3 -> halted=1, F_PC stays 3, queue drains; redir_pc=1 -> RUN resumes at address 1.
REQ-035 SHALL cover wrap and collision: redir_pc=0xFFFFFFFF -> next F_PC=0; redir_valid with halt_req together -> state RUN.
REQ-036 SHALL cover reset mid-run: rst_n low with 3 entries queued -> D_valid=0 and F_PC=0 asynchronously; with FETCH_PERF_EN, counters read 0.
